// File: rtl/s2_issue_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : s2_issue_scheduler
// Purpose  : Issue scheduler in front of the stage-2 range/renormalization
//            datapath. Buffers one symbol per cycle from stage 1 and issues
//            either a group of up to three consecutive Boolean symbols or a
//            single CDF symbol with its payload, one issue per cycle.
// Ports    : clk, reset (sync, active-low)
//            in_valid/in_ready/in_bool/in_symbol/in_payload/in_last : stage-1 side
//            out_valid/out_ready, bool_flag_1..3, out_symbol_1..3,
//            out_payload, out_last                                  : stage-2 side
// Options  : S2_SCHED_WAIT_EN - when defined, a partial Boolean group may wait
//            up to MAX_WAIT cycles (GATHER) for more Booleans before issuing.
// Revision : 1.0 - initial release
// ============================================================================
module s2_issue_scheduler #(
  parameter int SYMBOL_WIDTH  = 4,
  parameter int PAYLOAD_WIDTH = 81,
  parameter int DEPTH         = 4,
  parameter int MAX_WAIT      = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_bool,
  input  logic [SYMBOL_WIDTH-1:0]  in_symbol,
  input  logic [PAYLOAD_WIDTH-1:0] in_payload,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     bool_flag_1,
  output logic                     bool_flag_2,
  output logic                     bool_flag_3,
  output logic [SYMBOL_WIDTH-1:0]  out_symbol_1,
  output logic [SYMBOL_WIDTH-1:0]  out_symbol_2,
  output logic [SYMBOL_WIDTH-1:0]  out_symbol_3,
  output logic [PAYLOAD_WIDTH-1:0] out_payload,
  output logic                     out_last
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  // The scheduler state is a decode of buffer occupancy plus the wait timer,
  // so a freshly pushed entry is already issuable in the following cycle.
`ifdef S2_SCHED_WAIT_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_READY = 2'd1, S_GATHER = 2'd2} state_t;
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_SAT = WAIT_W'(MAX_WAIT);
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              partial;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_READY = 2'd1} state_t;
`endif
  state_t state;

  // Circular buffer
  logic [SYMBOL_WIDTH-1:0]  sym_mem_q [DEPTH];
  logic [PAYLOAD_WIDTH-1:0] pay_mem_q [DEPTH];
  logic [DEPTH-1:0]         bool_mem_q, last_mem_q;
  logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]         count_q, count_d;

  // Head window (three entries from rd_ptr)
  logic [2:0]              head_bool, head_last, head_avail;
  logic [SYMBOL_WIDTH-1:0] head_sym [3];
  logic [1:0]              grp_len;
  logic                    grp_last, grp_more;
  logic                    push, load;

  // Output register
  logic                     out_valid_q, out_valid_d;
  logic [2:0]               flags_q, flags_d;
  logic [SYMBOL_WIDTH-1:0]  osym1_q, osym1_d, osym2_q, osym2_d, osym3_q, osym3_d;
  logic [PAYLOAD_WIDTH-1:0] opay_q, opay_d;
  logic                     olast_q, olast_d;

  for (genvar gi = 0; gi < 3; gi++) begin : g_head
    logic [PTR_W-1:0] idx;
    assign idx            = rd_ptr_q + PTR_W'(gi);
    assign head_bool[gi]  = bool_mem_q[idx];
    assign head_last[gi]  = last_mem_q[idx];
    assign head_sym[gi]   = sym_mem_q[idx];
    assign head_avail[gi] = (count_q > CNT_W'(gi));
  end

  // Boolean run from the head: stops at a CDF entry, at a last entry, at 3.
  always_comb begin
    grp_len = 2'd0;
    if (head_avail[0]) begin
      grp_len = 2'd1;
      if (head_bool[0] && !head_last[0] && head_avail[1] && head_bool[1]) begin
        grp_len = 2'd2;
        if (!head_last[1] && head_avail[2] && head_bool[2]) begin
          grp_len = 2'd3;
        end
      end
    end
  end

  assign grp_last = (head_avail[0] && head_last[0])
                  | ((grp_len >= 2'd2) && head_last[1])
                  | ((grp_len == 2'd3) && head_last[2]);
  // An entry sits behind the group; the group cannot grow any further.
  assign grp_more = (count_q > CNT_W'(grp_len));

  assign in_ready = (count_q != DEPTH_CNT);
  assign push     = in_valid && in_ready;

`ifdef S2_SCHED_WAIT_EN
  assign partial = head_avail[0] && head_bool[0] && (grp_len != 2'd3)
                   && !grp_more && !grp_last;
`endif

  always_comb begin
    state = S_IDLE;
    if (count_q != '0) state = S_READY;
`ifdef S2_SCHED_WAIT_EN
    // Saturated timer means the partial group has waited long enough.
    if (partial && (wait_cnt_q != WAIT_SAT)) state = S_GATHER;
`endif
  end

  assign load = (state == S_READY) && (!out_valid_q || out_ready);

`ifdef S2_SCHED_WAIT_EN
  always_comb begin
    wait_cnt_d = '0;
    if (partial && !load) begin
      wait_cnt_d = (wait_cnt_q == WAIT_SAT) ? wait_cnt_q : wait_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) wait_cnt_q <= '0;
    else        wait_cnt_q <= wait_cnt_d;
  end
`endif

  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + (load ? PTR_W'(grp_len) : '0);
    count_d  = count_q + CNT_W'(push) - (load ? CNT_W'(grp_len) : '0);
  end

  always_comb begin
    out_valid_d = out_valid_q;
    flags_d     = flags_q;
    osym1_d     = osym1_q;
    osym2_d     = osym2_q;
    osym3_d     = osym3_q;
    opay_d      = opay_q;
    olast_d     = olast_q;
    if (load) begin
      out_valid_d = 1'b1;
      osym1_d     = head_sym[0];
      olast_d     = grp_last;
      if (head_bool[0]) begin
        flags_d = {grp_len == 2'd3, grp_len >= 2'd2, 1'b1};
        osym2_d = (grp_len >= 2'd2) ? head_sym[1] : '0;
        osym3_d = (grp_len == 2'd3) ? head_sym[2] : '0;
        opay_d  = '0;
      end else begin
        flags_d = 3'b000;
        osym2_d = '0;
        osym3_d = '0;
        opay_d  = pay_mem_q[rd_ptr_q];
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      flags_q     <= '0;
      osym1_q     <= '0;
      osym2_q     <= '0;
      osym3_q     <= '0;
      opay_q      <= '0;
      olast_q     <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      flags_q     <= flags_d;
      osym1_q     <= osym1_d;
      osym2_q     <= osym2_d;
      osym3_q     <= osym3_d;
      opay_q      <= opay_d;
      olast_q     <= olast_d;
    end
  end

  // Storage needs no reset: only entries below count are ever read.
  always_ff @(posedge clk) begin
    if (push) begin
      sym_mem_q[wr_ptr_q]  <= in_symbol;
      pay_mem_q[wr_ptr_q]  <= in_payload;
      bool_mem_q[wr_ptr_q] <= in_bool;
      last_mem_q[wr_ptr_q] <= in_last;
    end
  end

  assign out_valid    = out_valid_q;
  assign bool_flag_1  = flags_q[0];
  assign bool_flag_2  = flags_q[1];
  assign bool_flag_3  = flags_q[2];
  assign out_symbol_1 = osym1_q;
  assign out_symbol_2 = osym2_q;
  assign out_symbol_3 = osym3_q;
  assign out_payload  = opay_q;
  assign out_last     = olast_q;

endmodule
`default_nettype wire
